// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between the master and the apb_slave_mem completer.
// The pslverr signal exists only when APB_SLAVE_PSLVERR_EN is defined.
interface apb_slave_mem_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
`ifdef APB_SLAVE_PSLVERR_EN
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
`else
  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
`endif
endinterface

// File: rtl/apb_slave_mem.sv
// APB3 completer with a small register-file memory and programmable wait states.
// Optional APB_SLAVE_PSLVERR_EN flags out-of-range addresses instead of aliasing them.
//
//  state  | meaning
//  S_IDLE | waiting for psel; latches the request when it arrives
//  S_WAIT | counting wait states down; psel low aborts the transfer
//  S_DONE | pready high for one cycle; a write commits when leaving
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 4,
  parameter int MEM_DEPTH   = 4,
  parameter int WAIT_CYCLES = 2
) (
  input logic            pclk,
  input logic            presetn,
  apb_slave_mem_if.slave bus
);

  localparam int         IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
`ifdef APB_SLAVE_PSLVERR_EN
  logic                  pslverr_q, pslverr_d;
`endif

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic                  mem_we;

  logic [IDX_W-1:0]      bus_idx;
  logic                  bus_err;
  logic [IDX_W-1:0]      xfer_idx;
  logic                  xfer_write;
  logic                  xfer_err;
  logic                  enter_done;

  assign bus_idx = bus.paddr[IDX_W-1:0];

`ifdef APB_SLAVE_PSLVERR_EN
  // Address bits between the index and the memory-select MSB must be zero.
  logic [ADDR_WIDTH-2:0] bus_lo;
  assign bus_lo  = bus.paddr[ADDR_WIDTH-2:0];
  assign bus_err = |(bus_lo >> IDX_W);
`else
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    err_d      = err_q;
    prdata_d   = prdata_q;
    pready_d   = 1'b0;
`ifdef APB_SLAVE_PSLVERR_EN
    pslverr_d  = 1'b0;
`endif
    mem_we     = 1'b0;
    enter_done = 1'b0;
    xfer_idx   = idx_q;
    xfer_write = write_q;
    xfer_err   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.psel) begin
          idx_d      = bus_idx;
          wdata_d    = bus.pwdata;
          write_d    = bus.pwrite;
          err_d      = bus_err;
          // With no wait states the DONE entry happens on the latching edge,
          // so the read must use the live bus fields rather than the latches.
          xfer_idx   = bus_idx;
          xfer_write = bus.pwrite;
          xfer_err   = bus_err;
          if (WAIT_CYCLES == 0) begin
            enter_done = 1'b1;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!bus.psel) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        mem_we  = write_q && bus.psel && bus.penable && !err_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (enter_done) begin
      state_d  = S_DONE;
      pready_d = 1'b1;
`ifdef APB_SLAVE_PSLVERR_EN
      pslverr_d = xfer_err;
`endif
      if (xfer_err) begin
        prdata_d = '0;
      end else if (!xfer_write) begin
        prdata_d = mem_q[xfer_idx];
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
`ifdef APB_SLAVE_PSLVERR_EN
      pslverr_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      err_q     <= err_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
`ifdef APB_SLAVE_PSLVERR_EN
      pslverr_q <= pslverr_d;
`endif
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
`ifdef APB_SLAVE_PSLVERR_EN
  assign bus.pslverr = pslverr_q;
`endif

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: one instance with two wait states, one with none.
// Build with APB_SLAVE_PSLVERR_EN to exercise the out-of-range error path.
module tb_apb_slave_mem;

  localparam int AW = 4;
  localparam int DW = 4;

  typedef struct {
    logic          chk;
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } exp_t;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   npr2    = 0;
  int   npr0    = 0;
  int   n_before;

  exp_t q2[$];
  exp_t q0[$];

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b2 ();
  apb_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b0 ();

  apb_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(4), .WAIT_CYCLES(2)) dut2 (
    .pclk(pclk), .presetn(presetn), .bus(b2)
  );
  apb_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(4), .WAIT_CYCLES(0)) dut0 (
    .pclk(pclk), .presetn(presetn), .bus(b0)
  );

  logic err2_w, err0_w;
`ifdef APB_SLAVE_PSLVERR_EN
  assign err2_w = b2.pslverr;
  assign err0_w = b0.pslverr;
`else
  assign err2_w = 1'b0;
  assign err0_w = 1'b0;
`endif

  task automatic compare(input string nm, input exp_t e, input logic [DW-1:0] pd, input logic pe);
    checks++;
    if (cyc != e.cyc) begin
      errors++;
      $display("FAIL %s latency: pready at cycle %0d, required cycle %0d", nm, cyc, e.cyc);
    end
    if (e.chk) begin
      checks++;
      if (pd !== e.data) begin
        errors++;
        $display("FAIL %s prdata: got %h, required %h", nm, pd, e.data);
      end
    end
`ifdef APB_SLAVE_PSLVERR_EN
    checks++;
    if (pe !== e.err) begin
      errors++;
      $display("FAIL %s pslverr: got %b, required %b", nm, pe, e.err);
    end
`else
    if (pe !== 1'b0) $display("note: unexpected pslverr tie-off on %s", nm);
`endif
  endtask

  always @(negedge pclk) begin
    exp_t e;
    if (b2.pready === 1'b1) begin
      npr2++;
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut2 unexpected pready at cycle %0d, required none", cyc);
      end else begin
        e = q2.pop_front();
        compare("dut2", e, b2.prdata, err2_w);
      end
    end
    if (b0.pready === 1'b1) begin
      npr0++;
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0 unexpected pready at cycle %0d, required none", cyc);
      end else begin
        e = q0.pop_front();
        compare("dut0", e, b0.prdata, err0_w);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, expv);
    end
  endtask

  task automatic set_bus(input bit sel0, input logic ps, input logic pe, input logic pw,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (sel0) begin
      b0.psel = ps; b0.penable = pe; b0.pwrite = pw; b0.paddr = a; b0.pwdata = d;
    end else begin
      b2.psel = ps; b2.penable = pe; b2.pwrite = pw; b2.paddr = a; b2.pwdata = d;
    end
  endtask

  task automatic idle(input int n);
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_bus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that leaves DONE,
  // with psel/penable still driven so the caller may chain another transfer.
  task automatic apb_xfer(input bit sel0, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic c, input logic [DW-1:0] exp_d,
                          input logic exp_e);
    exp_t e;
    bit   got;
    int   w;
    w = sel0 ? 0 : 2;
    set_bus(sel0, 1'b1, 1'b0, wr, a, d);
    e.chk  = c;
    e.data = exp_d;
    e.err  = exp_e;
    e.cyc  = cyc + 1 + w;
    if (sel0) q0.push_back(e);
    else      q2.push_back(e);
    @(posedge pclk);
    #1;
    set_bus(sel0, 1'b1, 1'b1, wr, a, d);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge pclk);
      if (sel0 ? (b0.pready === 1'b1) : (b2.pready === 1'b1)) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: pready not seen within 40 cycles, required by cycle %0d",
               sel0 ? "dut0" : "dut2", e.cyc);
    end
    @(posedge pclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_bus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    presetn = 1'b0;
    repeat (2) @(posedge pclk);
    #2;
    chk("reset dut2 pready", b2.pready, 0);
    chk("reset dut2 prdata", b2.prdata, 0);
    chk("reset dut0 pready", b0.pready, 0);
    chk("reset dut0 prdata", b0.prdata, 0);
    @(posedge pclk);
    #3 presetn = 1'b1;
    idle(2);

    // dut2: memory starts cleared, then write/read with two wait states
    apb_xfer(1'b0, 1'b0, 4'd3, 4'h0, 1'b1, 4'h0, 1'b0);
    idle(1);
    apb_xfer(1'b0, 1'b1, 4'd1, 4'hA, 1'b0, 4'h0, 1'b0);
    idle(1);
    apb_xfer(1'b0, 1'b0, 4'd1, 4'h0, 1'b1, 4'hA, 1'b0);
    idle(2);

    // dut2: psel dropped during WAIT aborts the write of 0xF to addr 0
    n_before = npr2;
    set_bus(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'hF);
    @(posedge pclk);
    #1;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(4);
    chk("abort no pready", npr2, n_before);
    chk("abort prdata held", b2.prdata, 4'hA);
    apb_xfer(1'b0, 1'b0, 4'd0, 4'h0, 1'b1, 4'h0, 1'b0);
    idle(1);

    // dut2: back-to-back write then read of the same word
    apb_xfer(1'b0, 1'b1, 4'd3, 4'h3, 1'b0, 4'h0, 1'b0);
    apb_xfer(1'b0, 1'b0, 4'd3, 4'h0, 1'b1, 4'h3, 1'b0);
    idle(2);

    // dut2: reset asserted mid-WAIT of a write of 0x6 to addr 3
    set_bus(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 4'h6);
    @(posedge pclk);
    #1;
    set_bus(1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 4'h6);
    #3 presetn = 1'b0;
    #1;
    chk("mid-wait reset pready", b2.pready, 0);
    chk("mid-wait reset prdata", b2.prdata, 0);
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    #2 presetn = 1'b1;
    idle(2);
    apb_xfer(1'b0, 1'b0, 4'd3, 4'h0, 1'b1, 4'h0, 1'b0);
    idle(1);
    apb_xfer(1'b0, 1'b0, 4'd1, 4'h0, 1'b1, 4'h0, 1'b0);
    idle(2);

    // dut0: zero wait states
    apb_xfer(1'b1, 1'b1, 4'd2, 4'h5, 1'b0, 4'h0, 1'b0);
    idle(1);
    apb_xfer(1'b1, 1'b0, 4'd2, 4'h0, 1'b1, 4'h5, 1'b0);
    idle(1);
    apb_xfer(1'b1, 1'b1, 4'd3, 4'h3, 1'b0, 4'h0, 1'b0);
    apb_xfer(1'b1, 1'b0, 4'd3, 4'h0, 1'b1, 4'h3, 1'b0);
    idle(2);

    // dut0: out-of-range address 4'b0100
`ifdef APB_SLAVE_PSLVERR_EN
    apb_xfer(1'b1, 1'b1, 4'b0100, 4'h7, 1'b1, 4'h0, 1'b1);
    idle(1);
    apb_xfer(1'b1, 1'b0, 4'd0, 4'h0, 1'b1, 4'h0, 1'b0);
`else
    apb_xfer(1'b1, 1'b1, 4'b0100, 4'h7, 1'b0, 4'h0, 1'b0);
    idle(1);
    apb_xfer(1'b1, 1'b0, 4'd0, 4'h0, 1'b1, 4'h7, 1'b0);
`endif
    idle(4);

    chk("dut2 pending responses", q2.size(), 0);
    chk("dut0 pending responses", q0.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB3 completer stage directly downstream of the APB master.
- Consumes one master select line (psel1 or psel2), plus penable, pwrite, paddr and pwdata.
- Produces prdata and pready.
- Holds a small register-file memory.
- Inserts a programmable number of wait states, so the master's pready-driven penable/psel sequencing is exercised.

Parameters:
- ADDR_WIDTH, 4: paddr width; MSB is the master's memory-select bit and is ignored by this block.
- DATA_WIDTH, 4: pwdata/prdata width.
- MEM_DEPTH, 4: number of words; power of two, 2..2^(ADDR_WIDTH-1); index = paddr[log2(MEM_DEPTH)-1:0].
- WAIT_CYCLES, 2: wait states before pready; 0..15.

Ports:
- pclk  in  1  clock, all state on rising edge
- presetn  in  1  asynchronous active-low reset
- psel  in  1  select from master (psel1 or psel2)
- penable  in  1  access phase from master
- pwrite  in  1  1=write, 0=read
- paddr  in  ADDR_WIDTH  transfer address
- pwdata  in  DATA_WIDTH  write data
- prdata  out  DATA_WIDTH  read data, registered
- pready  out  1  transfer complete, registered, one-cycle pulse

Behaviour:
- Reset (async, presetn=0):
  - state=IDLE, pready=0, prdata=0, wait counter=0.
  - All memory words=0, latched addr/wdata/write=0.
  - Reset mid-transfer aborts with no memory update.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - pready=0.
  - Edge E0 with psel=1 (penable don't-care): latch paddr, pwrite, pwdata.
  - If WAIT_CYCLES=0, go to DONE.
  - Otherwise load cnt=WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - psel=0 at an edge: abort to IDLE; no write; prdata unchanged.
  - Else if cnt==0: go to DONE.
  - Else cnt decrements.
- Entering DONE:
  - Read: prdata <= mem[latched index].
  - Write: prdata unchanged.
  - pready <= 1.
- Latency: pready is high exactly in the cycle following edge E_WAIT_CYCLES, i.e. WAIT_CYCLES+1 edges after psel is first sampled.
- DONE (one cycle only): at the leaving edge, always go to IDLE and set pready <= 0.
  - Write: if latched pwrite=1 and psel&penable=1 at that edge, mem[index] <= latched wdata.
  - If psel or penable is low at that edge, the write is dropped.
- Back-to-back: a held or new psel in the IDLE cycle after DONE starts the next transfer; minimum 1 IDLE cycle between pready pulses.
- Bus inputs are ignored outside IDLE; the transfer uses the latched values.
- Read-after-write to the same word returns the new data, because the write commits before the next DONE entry.
- Index wrap: address bits above the index are ignored (aliased) unless the optional feature is compiled in.

Optional Feature:
- Macro: APB_SLAVE_PSLVERR_EN.
- Defined:
  - Adds output port pslverr (1 bit, reset 0), registered and aligned with pready.
  - Set when latched paddr[ADDR_WIDTH-2:log2(MEM_DEPTH)] is nonzero; bit range is empty (never error) if MEM_DEPTH=2^(ADDR_WIDTH-1).
  - On error: write suppressed, prdata <= 0, pready timing unchanged.
- Undefined: no pslverr port; out-of-range addresses alias onto mem.

Test Plan:
1. Reset: presetn low mid-WAIT -> pready=0, prdata=0 immediately; after release, read addr 3 returns 0.
2. WAIT_CYCLES=2, write 0xA to addr 1 -> pready high in 3rd cycle after psel sampled; then read addr 1 -> prdata=0xA with pready, same latency.
3. WAIT_CYCLES=0 -> write 0x5 to addr 2 gives pready in the cycle after psel sampled; read back 0x5.
4. Abort: psel dropped during WAIT on write of 0xF to addr 0 -> no pready; addr 0 still reads 0.
5. Back-to-back: write 0x3 to addr 3 then immediately read addr 3 -> two pready pulses separated by one IDLE cycle; read returns 0x3.
6. APB_SLAVE_PSLVERR_EN, defaults: write 0x7 to paddr=4'b0100 -> pslverr=1 with pready; addr 0 unchanged. Without macro, same write lands in addr 0.
